// File: rtl/layer_compositor.sv
// Final-stage compositor: priority-merges NUM_LAYERS sprite streams over a background colour,
// delays sync/blank, double-buffers enables at vsync falling edges. Macro: LAYER_COMPOSITOR_FLASH_EN.
module layer_compositor #(
  parameter int unsigned NUM_LAYERS = 3,
  parameter int unsigned SYNC_DELAY = 6,
  parameter int unsigned FRAME_W    = 8,
  parameter int unsigned FLASH_BIT  = 4
) (
  input  logic                       vclock,
  input  logic                       reset,
  input  logic                       hsync,
  input  logic                       vsync,
  input  logic                       blank,
  input  logic [24*NUM_LAYERS-1:0]   layer_pixels,
  input  logic [NUM_LAYERS-1:0]      layer_en,
  input  logic [NUM_LAYERS-1:0]      flash_mask,
  input  logic [23:0]                bg_color,
  output logic                       phsync,
  output logic                       pvsync,
  output logic                       pblank,
  output logic [23:0]                pixel,
  output logic [FRAME_W-1:0]         frame_count
);

  logic [SYNC_DELAY-1:0] hs_q, hs_d, vs_q, vs_d, bl_q, bl_d;
  logic                  vs_prev_q;
  logic                  boundary;
  logic                  blank_dly;
  logic [NUM_LAYERS-1:0] en_q;
  logic [NUM_LAYERS-1:0] vis;
  logic [FRAME_W-1:0]    fc_q;
  logic [23:0]           pixel_q, pixel_d;

  assign boundary = vs_prev_q & ~vsync;

  always_comb begin
    hs_d    = hs_q << 1;
    hs_d[0] = hsync;
    vs_d    = vs_q << 1;
    vs_d[0] = vsync;
    bl_d    = bl_q << 1;
    bl_d[0] = blank;
  end

  // Blank used for compositing is one stage short so pixel lands with pblank.
  generate
    if (SYNC_DELAY == 1) begin : g_blank_raw
      assign blank_dly = blank;
    end else begin : g_blank_tap
      assign blank_dly = bl_q[SYNC_DELAY-2];
    end
  endgenerate

`ifdef LAYER_COMPOSITOR_FLASH_EN
  logic [NUM_LAYERS-1:0] flash_q;

  always_ff @(posedge vclock) begin
    if (reset) begin
      flash_q <= '0;
    end else if (boundary) begin
      flash_q <= flash_mask;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      vis[i] = en_q[i] && (|layer_pixels[24*i +: 24]) && !(flash_q[i] && fc_q[FLASH_BIT]);
    end
  end
`else
  logic unused_flash;
  assign unused_flash = ^{flash_mask, fc_q[FLASH_BIT]};

  always_comb begin
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      vis[i] = en_q[i] && (|layer_pixels[24*i +: 24]);
    end
  end
`endif

  // Walk from lowest priority up so layer 0 overwrites last.
  always_comb begin
    pixel_d = bg_color;
    for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
      if (vis[i]) pixel_d = layer_pixels[24*i +: 24];
    end
    if (blank_dly) pixel_d = 24'h0;
  end

  always_ff @(posedge vclock) begin
    if (reset) begin
      hs_q      <= '1;
      vs_q      <= '1;
      bl_q      <= '1;
      vs_prev_q <= 1'b1;
      en_q      <= '1;
      fc_q      <= '0;
      pixel_q   <= '0;
    end else begin
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      bl_q      <= bl_d;
      vs_prev_q <= vsync;
      pixel_q   <= pixel_d;
      if (boundary) begin
        en_q <= layer_en;
        fc_q <= fc_q + 1'b1;
      end
    end
  end

  assign phsync      = hs_q[SYNC_DELAY-1];
  assign pvsync      = vs_q[SYNC_DELAY-1];
  assign pblank      = bl_q[SYNC_DELAY-1];
  assign pixel       = pixel_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: directed steps plus randomized traffic against a behavioural model.
module tb_layer_compositor;
  localparam int NL = 3;
  localparam int SD = 6;
  localparam int FW = 8;
  localparam int FB = 4;
`ifdef LAYER_COMPOSITOR_FLASH_EN
  localparam bit FlashOn = 1'b1;
`else
  localparam bit FlashOn = 1'b0;
`endif

  logic              vclock = 1'b0;
  logic              reset, hsync, vsync, blank;
  logic [24*NL-1:0]  layer_pixels;
  logic [NL-1:0]     layer_en, flash_mask;
  logic [23:0]       bg_color;
  logic              phsync, pvsync, pblank;
  logic [23:0]       pixel;
  logic [FW-1:0]     frame_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit        qhs[$], qvs[$], qbl[$];
  bit [NL-1:0] m_en, m_flash;
  int        m_fc;
  bit        m_vsprev;
  bit [23:0] m_pix;

  layer_compositor #(
    .NUM_LAYERS(NL), .SYNC_DELAY(SD), .FRAME_W(FW), .FLASH_BIT(FB)
  ) dut (
    .vclock(vclock), .reset(reset), .hsync(hsync), .vsync(vsync), .blank(blank),
    .layer_pixels(layer_pixels), .layer_en(layer_en), .flash_mask(flash_mask),
    .bg_color(bg_color), .phsync(phsync), .pvsync(pvsync), .pblank(pblank),
    .pixel(pixel), .frame_count(frame_count)
  );

  always #5 vclock = ~vclock;

  function automatic bit [23:0] lay(int i);
    return layer_pixels[24*i +: 24];
  endfunction

  function automatic void model_reset();
    qhs = {}; qvs = {}; qbl = {};
    for (int i = 0; i < SD; i++) begin
      qhs.push_back(1'b1); qvs.push_back(1'b1); qbl.push_back(1'b1);
    end
    m_pix = '0; m_fc = 0; m_vsprev = 1'b1; m_en = '1; m_flash = '0;
  endfunction

  // Outputs as the spec describes them, one clock edge at a time.
  function automatic void model_edge();
    bit found;
    if (reset) begin
      model_reset();
      return;
    end
    qhs.push_front(hsync); void'(qhs.pop_back());
    qvs.push_front(vsync); void'(qvs.pop_back());
    qbl.push_front(blank); void'(qbl.pop_back());
    found = 1'b0;
    m_pix = bg_color;
    for (int i = 0; i < NL; i++) begin
      if (!found && m_en[i] && lay(i) != 24'h0 &&
          !(FlashOn && m_flash[i] && ((m_fc >> FB) & 1) == 1)) begin
        m_pix = lay(i);
        found = 1'b1;
      end
    end
    if (qbl[SD-1]) m_pix = 24'h0;
    if (m_vsprev && !vsync) begin
      m_en = layer_en; m_flash = flash_mask; m_fc = (m_fc + 1) % (1 << FW);
    end
    m_vsprev = vsync;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge vclock);
    model_edge();
    #1;
    chk("phsync", 32'(phsync), 32'(qhs[SD-1]));
    chk("pvsync", 32'(pvsync), 32'(qvs[SD-1]));
    chk("pblank", 32'(pblank), 32'(qbl[SD-1]));
    chk("pixel", 32'(pixel), 32'(m_pix));
    chk("frame_count", 32'(frame_count), 32'(m_fc));
  endtask

  task automatic frame(input int len);
    vsync = 1'b0;
    repeat (2) cycle();
    vsync = 1'b1;
    repeat (len - 2) cycle();
  endtask

  initial begin
    model_reset();
    reset = 1'b1; hsync = 1'b1; vsync = 1'b1; blank = 1'b1;
    layer_pixels = '0; layer_en = '1; flash_mask = '0; bg_color = 24'h202020;
    repeat (3) cycle();
    chk("rst_phsync", 32'(phsync), 32'd1);
    chk("rst_pvsync", 32'(pvsync), 32'd1);
    chk("rst_pblank", 32'(pblank), 32'd1);
    chk("rst_pixel", 32'(pixel), 32'd0);

    // Sync latency
    reset = 1'b0; blank = 1'b0;
    repeat (10) cycle();
    hsync = 1'b0;
    cycle();
    hsync = 1'b1;
    repeat (4) begin
      cycle();
      chk("hs_early", 32'(phsync), 32'd1);
    end
    cycle();
    chk("hs_latency", 32'(phsync), 32'd0);
    cycle();

    // Priority
    layer_pixels = {24'h00FF00, 24'h0000FF, 24'hFF0000};
    cycle();
    chk("prio_l0", 32'(pixel), 32'hFF0000);
    layer_pixels[23:0] = 24'h0;
    cycle();
    chk("prio_l1", 32'(pixel), 32'h0000FF);
    layer_pixels = '0;
    cycle();
    chk("prio_bg", 32'(pixel), 32'h202020);

    // Blank alignment
    layer_pixels[23:0] = 24'hFF0000;
    blank = 1'b1;
    cycle();
    blank = 1'b0;
    repeat (4) cycle();
    cycle();
    chk("blank_pblank", 32'(pblank), 32'd1);
    chk("blank_pixel", 32'(pixel), 32'd0);
    cycle();
    chk("blank_after", 32'(pixel), 32'hFF0000);

    // Enable double-buffering
    layer_pixels = {24'h00FF00, 24'h0000FF, 24'hFF0000};
    layer_en = 3'b110;
    repeat (3) cycle();
    chk("en_pending", 32'(pixel), 32'hFF0000);
    vsync = 1'b0;
    cycle();
    chk("en_bnd_pixel", 32'(pixel), 32'hFF0000);
    chk("en_bnd_fc", 32'(frame_count), 32'd1);
    cycle();
    chk("en_applied", 32'(pixel), 32'h0000FF);
    vsync = 1'b1;
    layer_en = 3'b111;
    repeat (4) cycle();
    frame(6);

    // Flash over 32 frames
    flash_mask = 3'b001;
    frame(6);
    for (int f = 0; f < 32; f++) begin
      frame(5);
      chk("flash", 32'(pixel),
          (FlashOn && frame_count[FB]) ? 32'h0000FF : 32'hFF0000);
    end
    flash_mask = '0;

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      hsync = ($urandom_range(0, 7) != 0);
      blank = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) vsync = ~vsync;
      for (int i = 0; i < NL; i++)
        layer_pixels[24*i +: 24] = ($urandom_range(0, 2) == 0) ? 24'h0 : 24'($urandom);
      if ($urandom_range(0, 15) == 0) layer_en = NL'($urandom);
      if ($urandom_range(0, 15) == 0) flash_mask = NL'($urandom);
      if ($urandom_range(0, 3) == 0) bg_color = 24'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;

    // Wrap after 256 boundaries
    reset = 1'b1; vsync = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    for (int f = 0; f < 256; f++) frame(4);
    chk("fc_wrap", 32'(frame_count), 32'd0);

    // Reset coincident with a boundary
    layer_en = '0;
    frame(4);
    vsync = 1'b1;
    cycle();
    vsync = 1'b0; reset = 1'b1;
    cycle();
    chk("rstbnd_fc", 32'(frame_count), 32'd0);
    reset = 1'b0; vsync = 1'b1; blank = 1'b0; bg_color = 24'h123456;
    layer_pixels = {24'h00FF00, 24'h0000FF, 24'hFF0000};
    repeat (SD + 1) cycle();
    chk("rstbnd_en", 32'(pixel), 32'hFF0000);
    chk("rstbnd_fc2", 32'(frame_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
